fir_tap_sequencer: RTL and testbench

Upstream control stage for the multiply-accumulate cell; together they form a TAPS-tap FIR filter. It accepts input samples over a valid/ready handshake and keeps a delay line plus a writable coefficient file. For each sample it drives the cell's `k`/`x`/`ena` inputs for TAPS consecutive cycles, then reads back `acc_out` and emits one filtered result over a valid/ready handshake. The accumulator is never cleared. The result is the accumulator delta since sample acceptance, so any prior accumulator contents cancel out.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/fir_tap_sequencer_if.sv | 51 +++++
 rtl/fir_delay_line.sv | 34 +++
 rtl/mac_cell.sv | 29 ++
 rtl/fir_tap_sequencer.sv | 109 ++++++++++
 tb/tb_fir_tap_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC cell and the FIR tap sequencer that drives it.
package mac_pkg;

  localparam int MAC_WID = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2,
    OUT    = 2'd3
  } state_e;

  // Index width for n entries; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Bundle of coefficient-write, sample-in, MAC-drive and result-out signals of the tap sequencer.
interface fir_tap_sequencer_if import mac_pkg::*; #(
  parameter int WID  = MAC_WID,
  parameter int TAPS = 8
);
  localparam int AW = clog2(TAPS);

  logic             coef_we;
  logic [AW-1:0]    coef_addr;
  logic [WID-1:0]   coef_data;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds its data until that edge, ready never waits on valid.
  logic             s_valid;
  logic             s_ready;
  logic [WID-1:0]   s_data;

  logic             mac_ena;
  logic [WID-1:0]   mac_k;
  logic [WID-1:0]   mac_x;
  logic [2*WID-1:0] mac_acc;

  logic             y_valid;
  logic             y_ready;
  logic [2*WID-1:0] y_data;

  logic [1:0]       dbg_state;

  modport slave (
    input  coef_we, coef_addr, coef_data,
    input  s_valid, s_data,
    output s_ready,
    output mac_ena, mac_k, mac_x,
    input  mac_acc,
    output y_valid, y_data,
    input  y_ready,
    output dbg_state
  );

  modport master (
    output coef_we, coef_addr, coef_data,
    output s_valid, s_data,
    input  s_ready,
    input  mac_ena, mac_k, mac_x,
    output mac_acc,
    input  y_valid, y_data,
    output y_ready,
    input  dbg_state
  );

endinterface

// File: rtl/fir_delay_line.sv
// Sample delay line: entry 0 is the newest sample; one combinational indexed read port.
module fir_delay_line import mac_pkg::*; #(
  parameter  int WID  = MAC_WID,
  parameter  int TAPS = 8,
  localparam int AW   = clog2(TAPS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           shift,
  input  logic [WID-1:0] din,
  input  logic [AW-1:0]  idx,
  output logic [WID-1:0] dout
);

  logic [WID-1:0] dly [TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) dly[i] <= '0;
    end else if (shift) begin
      dly[0] <= din;
      for (int i = 1; i < TAPS; i++) dly[i] <= dly[i-1];
    end
  end

  // Indices past the last tap read as zero rather than aliasing.
  always_comb begin
    dout = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (idx == AW'(i)) dout = dly[i];
    end
  end

endmodule

// File: rtl/mac_cell.sv
// Multiply-accumulate cell: acc_out += k*x on each ena cycle, with a load path for presetting.
module mac_cell import mac_pkg::*; #(
  parameter int WID = MAC_WID
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic signed [WID-1:0] k,
  input  logic signed [WID-1:0] x,
  input  logic                  load,
  input  logic [2*WID-1:0]      load_val,
  output logic [2*WID-1:0]      acc_out
);

  logic signed [2*WID-1:0] prod;

  assign prod = (2*WID)'(k) * (2*WID)'(x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= '0;
    end else if (load) begin
      acc_out <= load_val;
    end else if (ena) begin
      acc_out <= acc_out + prod;
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR control stage: per sample, issues TAPS coefficient/sample pairs to the MAC and
// reports the accumulator growth over that sequence as the filter output.
module fir_tap_sequencer import mac_pkg::*; #(
  parameter int WID  = MAC_WID,
  parameter int TAPS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_tap_sequencer_if.slave   bus
);

  localparam int AW = clog2(TAPS);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_RUN    = 2'(RUN);
  localparam logic [1:0] S_SETTLE = 2'(SETTLE);
  localparam logic [1:0] S_OUT    = 2'(OUT);

  logic [1:0]       state;
  logic [AW-1:0]    cnt;
  logic [2*WID-1:0] base;
  logic [2*WID-1:0] y_reg;
  logic [WID-1:0]   coef [TAPS];
  logic [WID-1:0]   coef_rd;
  logic [WID-1:0]   dly_rd;
  logic             accept;
  logic             last_tap;
  logic             running;

  assign accept   = bus.s_valid && (state == S_IDLE);
  assign last_tap = (cnt == AW'(TAPS - 1));
  assign running  = (state == S_RUN);

  // The accumulator is never cleared, so the result is measured against the
  // value it held when the sample was accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      base  <= '0;
      y_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.s_valid) begin
            state <= S_RUN;
            cnt   <= '0;
            base  <= bus.mac_acc;
          end
        end
        S_RUN: begin
          if (last_tap) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        S_SETTLE: begin
          y_reg <= bus.mac_acc - base;
          state <= S_OUT;
        end
        S_OUT: begin
          if (bus.y_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else if (bus.coef_we) begin
      for (int i = 0; i < TAPS; i++) begin
        if (bus.coef_addr == AW'(i)) coef[i] <= bus.coef_data;
      end
    end
  end

  // Same-cycle write and read of one index returns the pre-write value.
  always_comb begin
    coef_rd = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (cnt == AW'(i)) coef_rd = coef[i];
    end
  end

  fir_delay_line #(
    .WID  (WID),
    .TAPS (TAPS)
  ) u_delay_line (
    .clk   (clk),
    .rst_n (reset),
    .shift (accept),
    .din   (bus.s_data),
    .idx   (cnt),
    .dout  (dly_rd)
  );

  assign bus.s_ready   = (state == S_IDLE);
  assign bus.y_valid   = (state == S_OUT);
  assign bus.y_data    = y_reg;
  assign bus.mac_ena   = running;
  assign bus.mac_k     = running ? coef_rd : '0;
  assign bus.mac_x     = running ? dly_rd  : '0;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for the tap sequencer driving real MAC cells (8-tap and 1-tap instances).
module tb_fir_tap_sequencer;
  import mac_pkg::*;

  localparam int W = 16;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mac_rst_n = 1'b0;
  logic        mac_load = 1'b0;
  logic [31:0] mac_load_val = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;

  fir_tap_sequencer_if #(.WID(W), .TAPS(T)) bus8 ();
  fir_tap_sequencer_if #(.WID(W), .TAPS(1)) bus1 ();

  fir_tap_sequencer #(.WID(W), .TAPS(T)) u_dut8 (.clk(clk), .reset(rst_n), .bus(bus8.slave));
  fir_tap_sequencer #(.WID(W), .TAPS(1)) u_dut1 (.clk(clk), .reset(rst_n), .bus(bus1.slave));

  mac_cell #(.WID(W)) u_mac8 (
    .clk(clk), .rst_n(mac_rst_n), .ena(bus8.mac_ena), .k(bus8.mac_k), .x(bus8.mac_x),
    .load(mac_load), .load_val(mac_load_val), .acc_out(bus8.mac_acc)
  );
  mac_cell #(.WID(W)) u_mac1 (
    .clk(clk), .rst_n(mac_rst_n), .ena(bus1.mac_ena), .k(bus1.mac_k), .x(bus1.mac_x),
    .load(1'b0), .load_val(32'h0), .acc_out(bus1.mac_acc)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [15:0] cm [T];
  logic [15:0] hist [T];
  bit          busy;
  int          phase;
  logic [31:0] job;
  logic [31:0] y_hold;
  logic [31:0] exp_q[$];
  bit          m_run, m_take, m_acc;
  logic [15:0] exp_k, exp_x;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
      phase = 0;
      y_hold = '0;
      exp_q.delete();
      for (int i = 0; i < T; i++) begin
        cm[i] = '0;
        hist[i] = '0;
      end
    end else begin
      m_run = busy && (phase >= 1) && (phase <= T);
      exp_k = '0;
      exp_x = '0;
      if (m_run) begin
        exp_k = cm[phase-1];
        exp_x = hist[phase-1];
      end
      chk("s_ready", bus8.s_ready, !busy);
      chk("mac_ena", bus8.mac_ena, m_run);
      chk("mac_k", bus8.mac_k, exp_k);
      chk("mac_x", bus8.mac_x, exp_x);
      chk("y_valid", bus8.y_valid, busy && (phase >= T + 2));
      chk("y_data", bus8.y_data, y_hold);

      m_take = busy && (phase >= T + 2) && bus8.y_ready;
      m_acc  = !busy && bus8.s_valid;
      if (bus8.coef_we && (int'(bus8.coef_addr) < T)) cm[bus8.coef_addr] = bus8.coef_data;
      if (busy) begin
        if (phase == T + 1) y_hold = job;
        if (m_take) busy = 1'b0;
        else phase++;
      end
      if (m_acc) begin
        for (int i = T - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bus8.s_data;
        job = '0;
        for (int i = 0; i < T; i++) job = job + 32'($signed(cm[i])) * 32'($signed(hist[i]));
        exp_q.push_back(job);
        busy = 1'b1;
        phase = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_coef(input int a, input logic [15:0] v);
    bus8.coef_we = 1'b1;
    bus8.coef_addr = 3'(a);
    bus8.coef_data = v;
    tick();
    bus8.coef_we = 1'b0;
  endtask

  task automatic send(input logic [15:0] v);
    bit ok = 1'b0;
    bus8.s_valid = 1'b1;
    bus8.s_data = v;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus8.s_ready) begin
        ok = 1'b1;
        last_acc = cyc;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    tick();
    bus8.s_valid = 1'b0;
  endtask

  task automatic get_result(input int pre, output logic [31:0] y, output int lat);
    bit ok = 1'b0;
    y = '0;
    lat = 0;
    repeat (pre) tick();
    bus8.y_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus8.y_valid) begin
        ok = 1'b1;
        y = bus8.y_data;
        lat = cyc - last_acc;
        break;
      end
    end
    if (!ok) chk("get_timeout", 0, 1);
    else if (exp_q.size() == 0) chk("sb_empty", 1, 0);
    else chk("sb_result", y, exp_q.pop_front());
    tick();
    bus8.y_ready = 1'b0;
  endtask

  task automatic run1(input logic [15:0] v, output logic [31:0] y);
    bit ok = 1'b0;
    y = '0;
    bus1.s_valid = 1'b1;
    bus1.s_data = v;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus1.s_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("t1_send_timeout", 0, 1);
    tick();
    bus1.s_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus1.y_valid) begin ok = 1'b1; y = bus1.y_data; break; end
    end
    if (!ok) chk("t1_get_timeout", 0, 1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] y;
  logic [31:0] y0;
  int          lat;
  int          imp_exp [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0};

  initial begin
    bus8.coef_we = 1'b0; bus8.coef_addr = '0; bus8.coef_data = '0;
    bus8.s_valid = 1'b0; bus8.s_data = '0; bus8.y_ready = 1'b0;
    bus1.coef_we = 1'b0; bus1.coef_addr = '0; bus1.coef_data = '0;
    bus1.s_valid = 1'b0; bus1.s_data = '0; bus1.y_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mac_rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", bus8.s_ready, 1);
    chk("rst_y_valid", bus8.y_valid, 0);
    chk("rst_mac_ena", bus8.mac_ena, 0);
    chk("rst_y_data", bus8.y_data, 0);
    tick();

    // accumulator preloaded with unrelated contents
    mac_load = 1'b1;
    mac_load_val = 32'h12345678;
    tick();
    mac_load = 1'b0;
    @(negedge clk);
    chk("preload", bus8.mac_acc, 32'h12345678);
    tick();
    write_coef(0, 16'd3);
    send(16'd5);
    get_result(0, y, lat);
    chk("acc_offset", y, 32'd15);

    // all-ones coefficients
    do_reset();
    for (int i = 0; i < T; i++) write_coef(i, 16'd1);
    send(16'd1);
    get_result(0, y, lat);
    chk("ones_1", y, 32'd1);
    chk("ones_latency", lat, 10);
    send(16'd2);
    get_result(0, y, lat);
    chk("ones_2", y, 32'd3);
    send(16'd3);
    get_result(0, y, lat);
    chk("ones_3", y, 32'd6);

    // impulse response
    do_reset();
    for (int i = 0; i < T; i++) write_coef(i, 16'(i + 1));
    for (int k = 0; k < 10; k++) begin
      send((k == 0) ? 16'd1 : 16'd0);
      get_result(0, y, lat);
      chk($sformatf("impulse_%0d", k), y, 32'(imp_exp[k]));
    end

    // extremes, 8 taps
    do_reset();
    for (int i = 0; i < T; i++) write_coef(i, 16'h8000);
    for (int k = 0; k < 10; k++) begin
      send(16'h8000);
      get_result(0, y, lat);
      if (k == 0) chk("extreme8_first", y, 32'h40000000);
      if (k == 9) chk("extreme8_full", y, 32'h00000000);
    end

    // backpressure in OUT
    send(16'd1);
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (bus8.y_valid) begin seen = 1'b1; break; end
      end
      if (!seen) chk("bp_timeout", 0, 1);
    end
    y0 = bus8.y_data;
    chk("bp_result", y0, 32'hBFFF8000);
    if (exp_q.size() != 0) chk("bp_sb", y0, exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      tick();
      bus8.s_valid = (i % 2 == 0);
      bus8.s_data = 16'h7777;
      @(negedge clk);
      chk("bp_y_valid", bus8.y_valid, 1);
      chk("bp_y_data", bus8.y_data, y0);
      chk("bp_s_ready", bus8.s_ready, 0);
    end
    tick();
    bus8.s_valid = 1'b0;
    bus8.y_ready = 1'b1;
    @(negedge clk);
    tick();
    bus8.y_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_idle", bus8.s_ready, 1);
    tick();
    send(16'd0);
    get_result(0, y, lat);
    chk("bp_next", y, 32'h7FFF8000);

    // extremes, single tap, and out-of-range coefficient index
    bus1.coef_we = 1'b1;
    bus1.coef_addr = 1'b0;
    bus1.coef_data = 16'h8000;
    tick();
    bus1.coef_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      run1(16'h8000, y);
      if (k == 0) chk("extreme1_first", y, 32'h40000000);
      if (k == 9) chk("extreme1_last", y, 32'h40000000);
    end
    bus1.coef_we = 1'b1;
    bus1.coef_addr = 1'b1;
    bus1.coef_data = 16'd7;
    tick();
    bus1.coef_we = 1'b0;
    run1(16'd2, y);
    chk("t1_addr_ignored", y, 32'hFFFF0000);

    // reset in the middle of a sequence
    send(16'd3);
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_y_valid", bus8.y_valid, 0);
    chk("mid_rst_mac_ena", bus8.mac_ena, 0);
    chk("mid_rst_y_data", bus8.y_data, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_s_ready", bus8.s_ready, 1);
    tick();
    write_coef(0, 16'd2);
    write_coef(1, 16'd5);
    send(16'd4);
    get_result(0, y, lat);
    chk("after_rst_1", y, 32'd8);
    send(16'hFFFF);
    get_result(0, y, lat);
    chk("after_rst_2", y, 32'd18);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 2) == 0) write_coef(int'($urandom_range(0, T - 1)), 16'($urandom));
      repeat ($urandom_range(0, 2)) tick();
      send(16'($urandom));
      get_result(int'($urandom_range(0, 4)), y, lat);
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
